// File: rtl/mat_res_store_buffer_if.sv
// mat_res_store_buffer_if
//   Bundles every non-clock/reset signal of the write-back store buffer:
//   the store push channel from the memory stage, the load request channel
//   from operand fetch, the single-port data memory port and the status flags.
//   Modports:
//     slave  - the store buffer's view (consumes pushes/loads/dmem_dout,
//              drives grants, memory port and status).
//     master - the surrounding environment's view (the mirror of slave).
interface mat_res_store_buffer_if #(
  parameter int PE_ELEMENTS = 4,
  parameter int DMEM_DEPTH  = 1024,
  parameter int DATA_LEN    = 32,
  parameter int FIFO_DEPTH  = 4
);
  localparam int DRAM_ADDR_WIDTH = $clog2(DMEM_DEPTH / PE_ELEMENTS);
  localparam int ROW_W           = PE_ELEMENTS * DATA_LEN;
  localparam int CNT_W           = $clog2(FIFO_DEPTH) + 1;

  logic                       mat_res_en;
  logic [DRAM_ADDR_WIDTH-1:0] mat_res_addr;
  logic [ROW_W-1:0]           mat_res_din;
  logic                       ld_req;
  logic [DRAM_ADDR_WIDTH-1:0] ld_addr;
  logic                       ld_gnt;
  logic                       ld_valid;
  logic [ROW_W-1:0]           ld_rdata;
  logic                       dmem_en;
  logic                       dmem_we;
  logic [DRAM_ADDR_WIDTH-1:0] dmem_addr;
  logic [ROW_W-1:0]           dmem_din;
  logic [ROW_W-1:0]           dmem_dout;
  logic                       wb_full;
  logic                       wb_empty;
  logic [CNT_W-1:0]           wb_count;
  logic                       overflow_err;

  modport slave (
    input  mat_res_en, mat_res_addr, mat_res_din, ld_req, ld_addr, dmem_dout,
    output ld_gnt, ld_valid, ld_rdata, dmem_en, dmem_we, dmem_addr, dmem_din,
           wb_full, wb_empty, wb_count, overflow_err
  );

  modport master (
    output mat_res_en, mat_res_addr, mat_res_din, ld_req, ld_addr, dmem_dout,
    input  ld_gnt, ld_valid, ld_rdata, dmem_en, dmem_we, dmem_addr, dmem_din,
           wb_full, wb_empty, wb_count, overflow_err
  );
endinterface

// File: rtl/mat_res_store_buffer.sv
// mat_res_store_buffer
//   Write-back store buffer between the SIMD memory stage and the single-port
//   data memory. Full-row stores are queued in a small circular FIFO and
//   drained into memory; vector loads share the same port. Loads win the port
//   unless the FIFO is full, and a load whose row matches any queued store
//   waits until those stores have drained so it always sees the newest data.
//   Ports:
//     clk  - single clock, rising edge
//     rstn - synchronous active-low reset (control state only)
//     bus  - mat_res_store_buffer_if.slave: store push, load request/grant/
//            data, data memory port, wb_full/wb_empty/wb_count/overflow_err
module mat_res_store_buffer #(
  parameter int PE_ELEMENTS = 4,
  parameter int DMEM_DEPTH  = 1024,
  parameter int DATA_LEN    = 32,
  parameter int FIFO_DEPTH  = 4
) (
  input logic                   clk,
  input logic                   rstn,
  mat_res_store_buffer_if.slave bus
);
  localparam int DRAM_ADDR_WIDTH = $clog2(DMEM_DEPTH / PE_ELEMENTS);
  localparam int ROW_W           = PE_ELEMENTS * DATA_LEN;
  localparam int PTR_W           = $clog2(FIFO_DEPTH);
  localparam int CNT_W           = PTR_W + 1;

  logic [DRAM_ADDR_WIDTH-1:0] r_addr [FIFO_DEPTH];
  logic [ROW_W-1:0]           r_data [FIFO_DEPTH];
  logic [PTR_W-1:0]           r_wr_ptr;
  logic [PTR_W-1:0]           r_rd_ptr;
  logic [CNT_W-1:0]           r_count;
  logic                       r_overflow;
  logic                       r_ld_vld_p1;

  logic                       w_full;
  logic                       w_empty;
  logic                       w_push;
  logic                       w_hazard;
  logic                       w_store_issue;
  logic                       w_load_issue;
  logic [PTR_W-1:0]           w_offset;

  assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  // A push into a full FIFO is dropped even if a pop happens the same cycle.
  assign w_push  = bus.mat_res_en && !w_full;

  // An entry is occupied when its distance from the read pointer (mod depth)
  // is below the count; every occupied entry is compared against ld_addr.
  always_comb begin
    w_hazard = 1'b0;
    w_offset = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      w_offset = PTR_W'(i) - r_rd_ptr;
      if (({1'b0, w_offset} < r_count) && (r_addr[i] == bus.ld_addr))
        w_hazard = 1'b1;
    end
    w_hazard = w_hazard && bus.ld_req;
  end

  // Port arbitration: full FIFO drains first, then a clean load, then any
  // pending store. Nothing reaches the memory port while reset is held.
  assign w_store_issue = rstn && !w_empty && (w_full || !(bus.ld_req && !w_hazard));
  assign w_load_issue  = rstn && !w_full && bus.ld_req && !w_hazard;

  assign bus.dmem_en      = w_store_issue || w_load_issue;
  assign bus.dmem_we      = w_store_issue;
  assign bus.dmem_addr    = w_load_issue ? bus.ld_addr : r_addr[r_rd_ptr];
  assign bus.dmem_din     = r_data[r_rd_ptr];
  assign bus.ld_gnt       = w_load_issue;
  assign bus.ld_valid     = r_ld_vld_p1;
  assign bus.ld_rdata     = bus.dmem_dout;
  assign bus.wb_full      = w_full;
  assign bus.wb_empty     = w_empty;
  assign bus.wb_count     = r_count;
  assign bus.overflow_err = r_overflow;

  // ---- stage p0 -> p1: FIFO control, overflow flag, load-valid pipeline ----
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_ld_vld_p1 <= 1'b0;
    end else begin
      if (w_push)        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_store_issue) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_store_issue})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (bus.mat_res_en && w_full) r_overflow <= 1'b1;
      r_ld_vld_p1 <= w_load_issue;
    end
  end

  // FIFO payload storage; contents are qualified by the control state above.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wr_ptr] <= bus.mat_res_addr;
      r_data[r_wr_ptr] <= bus.mat_res_din;
    end
  end
endmodule

// File: tb/tb_mat_res_store_buffer.sv
// tb_mat_res_store_buffer
//   Directed bench for mat_res_store_buffer with default parameters
//   (row address 8 bits, row data 128 bits, 4-entry FIFO). Includes a
//   one-cycle-latency single-port memory model on the dmem port.
module tb_mat_res_store_buffer;
  logic clk;
  logic rstn;
  int   n_checks;
  int   n_pass;

  logic [127:0] mem [256];
  logic [127:0] mem_dout;

  mat_res_store_buffer_if #(.PE_ELEMENTS(4), .DMEM_DEPTH(1024), .DATA_LEN(32), .FIFO_DEPTH(4)) bus ();

  mat_res_store_buffer #(.PE_ELEMENTS(4), .DMEM_DEPTH(1024), .DATA_LEN(32), .FIFO_DEPTH(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.dmem_en && bus.dmem_we)  mem[bus.dmem_addr] <= bus.dmem_din;
    if (bus.dmem_en && !bus.dmem_we) mem_dout <= mem[bus.dmem_addr];
  end
  assign bus.dmem_dout = mem_dout;

  function automatic logic [127:0] row4(input logic [31:0] a, b, c, d);
    return {a, b, c, d};
  endfunction

  task automatic test_reset();
    @(negedge clk);
    bus.ld_req = 1'b1; bus.ld_addr = 8'd7;
    #1;
    n_checks++; if (bus.wb_empty !== 1'b1) $display("FAIL reset_empty got %0b want 1", bus.wb_empty); else n_pass++;
    n_checks++; if (bus.wb_full !== 1'b0) $display("FAIL reset_full got %0b want 0", bus.wb_full); else n_pass++;
    n_checks++; if (bus.wb_count !== 3'd0) $display("FAIL reset_count got %0d want 0", bus.wb_count); else n_pass++;
    n_checks++; if (bus.ld_valid !== 1'b0) $display("FAIL reset_ld_valid got %0b want 0", bus.ld_valid); else n_pass++;
    n_checks++; if (bus.overflow_err !== 1'b0) $display("FAIL reset_overflow got %0b want 0", bus.overflow_err); else n_pass++;
    n_checks++; if (bus.ld_gnt !== 1'b0) $display("FAIL reset_ld_gnt got %0b want 0", bus.ld_gnt); else n_pass++;
    n_checks++; if (bus.dmem_en !== 1'b0) $display("FAIL reset_dmem_en got %0b want 0", bus.dmem_en); else n_pass++;
    @(negedge clk);
    rstn = 1'b1; bus.ld_req = 1'b0;
  endtask

  task automatic test_single_store();
    @(negedge clk);
    bus.mat_res_en = 1'b1; bus.mat_res_addr = 8'd5; bus.mat_res_din = row4(1, 2, 3, 4);
    @(negedge clk);
    bus.mat_res_en = 1'b0;
    #1;
    n_checks++; if (bus.dmem_we !== 1'b1) $display("FAIL single_we got %0b want 1", bus.dmem_we); else n_pass++;
    n_checks++; if (bus.dmem_addr !== 8'd5) $display("FAIL single_addr got %0d want 5", bus.dmem_addr); else n_pass++;
    n_checks++; if (bus.dmem_din !== row4(1, 2, 3, 4)) $display("FAIL single_din got %h want %h", bus.dmem_din, row4(1, 2, 3, 4)); else n_pass++;
    n_checks++; if (bus.wb_count !== 3'd1) $display("FAIL single_count got %0d want 1", bus.wb_count); else n_pass++;
    @(negedge clk); #1;
    n_checks++; if (bus.wb_empty !== 1'b1) $display("FAIL single_empty_after got %0b want 1", bus.wb_empty); else n_pass++;
    n_checks++; if (bus.dmem_en !== 1'b0) $display("FAIL single_idle_en got %0b want 0", bus.dmem_en); else n_pass++;
  endtask

  task automatic test_load_priority();
    @(negedge clk);
    bus.ld_req = 1'b1; bus.ld_addr = 8'd9;
    bus.mat_res_en = 1'b1; bus.mat_res_addr = 8'd10; bus.mat_res_din = row4(32'hA0, 32'hA1, 32'hA2, 32'hA3);
    #1;
    n_checks++; if (bus.ld_gnt !== 1'b1) $display("FAIL prio_gnt0 got %0b want 1", bus.ld_gnt); else n_pass++;
    @(negedge clk);
    bus.mat_res_addr = 8'd11; bus.mat_res_din = row4(32'hB0, 32'hB1, 32'hB2, 32'hB3);
    #1;
    n_checks++; if (bus.ld_gnt !== 1'b1) $display("FAIL prio_gnt1 got %0b want 1", bus.ld_gnt); else n_pass++;
    n_checks++; if (bus.dmem_we !== 1'b0) $display("FAIL prio_we1 got %0b want 0", bus.dmem_we); else n_pass++;
    n_checks++; if (bus.dmem_addr !== 8'd9) $display("FAIL prio_addr1 got %0d want 9", bus.dmem_addr); else n_pass++;
    n_checks++; if (bus.ld_valid !== 1'b1) $display("FAIL prio_valid1 got %0b want 1", bus.ld_valid); else n_pass++;
    @(negedge clk);
    bus.mat_res_en = 1'b0;
    #1;
    n_checks++; if (bus.wb_count !== 3'd2) $display("FAIL prio_count2 got %0d want 2", bus.wb_count); else n_pass++;
    n_checks++; if (bus.ld_gnt !== 1'b1) $display("FAIL prio_gnt2 got %0b want 1", bus.ld_gnt); else n_pass++;
    @(negedge clk);
    bus.ld_req = 1'b0;
    #1;
    n_checks++; if (bus.ld_valid !== 1'b1) $display("FAIL prio_valid3 got %0b want 1", bus.ld_valid); else n_pass++;
    n_checks++; if (bus.dmem_we !== 1'b1) $display("FAIL prio_drain_we0 got %0b want 1", bus.dmem_we); else n_pass++;
    n_checks++; if (bus.dmem_addr !== 8'd10) $display("FAIL prio_drain_addr0 got %0d want 10", bus.dmem_addr); else n_pass++;
    n_checks++; if (bus.dmem_din !== row4(32'hA0, 32'hA1, 32'hA2, 32'hA3)) $display("FAIL prio_drain_din0 got %h", bus.dmem_din); else n_pass++;
    @(negedge clk); #1;
    n_checks++; if (bus.ld_valid !== 1'b0) $display("FAIL prio_valid4 got %0b want 0", bus.ld_valid); else n_pass++;
    n_checks++; if (bus.dmem_addr !== 8'd11) $display("FAIL prio_drain_addr1 got %0d want 11", bus.dmem_addr); else n_pass++;
    n_checks++; if (bus.dmem_din !== row4(32'hB0, 32'hB1, 32'hB2, 32'hB3)) $display("FAIL prio_drain_din1 got %h", bus.dmem_din); else n_pass++;
    @(negedge clk); #1;
    n_checks++; if (bus.wb_empty !== 1'b1) $display("FAIL prio_empty got %0b want 1", bus.wb_empty); else n_pass++;
  endtask

  task automatic test_raw_hazard();
    @(negedge clk);
    bus.mat_res_en = 1'b1; bus.mat_res_addr = 8'd3; bus.mat_res_din = row4(32'hC0DE0001, 32'hC0DE0002, 32'hC0DE0003, 32'hC0DE0004);
    @(negedge clk);
    bus.mat_res_en = 1'b0; bus.ld_req = 1'b1; bus.ld_addr = 8'd3;
    #1;
    n_checks++; if (bus.ld_gnt !== 1'b0) $display("FAIL raw_gnt_blocked got %0b want 0", bus.ld_gnt); else n_pass++;
    n_checks++; if (bus.dmem_we !== 1'b1) $display("FAIL raw_store_first got %0b want 1", bus.dmem_we); else n_pass++;
    n_checks++; if (bus.dmem_addr !== 8'd3) $display("FAIL raw_store_addr got %0d want 3", bus.dmem_addr); else n_pass++;
    @(negedge clk); #1;
    n_checks++; if (bus.ld_gnt !== 1'b1) $display("FAIL raw_gnt got %0b want 1", bus.ld_gnt); else n_pass++;
    n_checks++; if (bus.dmem_we !== 1'b0) $display("FAIL raw_load_we got %0b want 0", bus.dmem_we); else n_pass++;
    @(negedge clk);
    bus.ld_req = 1'b0;
    #1;
    n_checks++; if (bus.ld_valid !== 1'b1) $display("FAIL raw_valid got %0b want 1", bus.ld_valid); else n_pass++;
    n_checks++; if (bus.ld_rdata !== row4(32'hC0DE0001, 32'hC0DE0002, 32'hC0DE0003, 32'hC0DE0004)) $display("FAIL raw_rdata got %h", bus.ld_rdata); else n_pass++;
  endtask

  task automatic test_full_overflow();
    @(negedge clk);
    bus.ld_req = 1'b1; bus.ld_addr = 8'd200;
    bus.mat_res_en = 1'b1; bus.mat_res_addr = 8'd20; bus.mat_res_din = row4(20, 20, 20, 20);
    #1;
    n_checks++; if (bus.ld_gnt !== 1'b1) $display("FAIL full_gnt_fill got %0b want 1", bus.ld_gnt); else n_pass++;
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      bus.mat_res_addr = 8'(20 + k); bus.mat_res_din = row4(20 + k, 20 + k, 20 + k, 20 + k);
    end
    @(negedge clk);
    bus.mat_res_addr = 8'd24; bus.mat_res_din = row4(24, 24, 24, 24);
    #1;
    n_checks++; if (bus.wb_full !== 1'b1) $display("FAIL full_flag got %0b want 1", bus.wb_full); else n_pass++;
    n_checks++; if (bus.wb_count !== 3'd4) $display("FAIL full_count got %0d want 4", bus.wb_count); else n_pass++;
    n_checks++; if (bus.dmem_we !== 1'b1) $display("FAIL full_forced_store got %0b want 1", bus.dmem_we); else n_pass++;
    n_checks++; if (bus.dmem_addr !== 8'd20) $display("FAIL full_store_addr got %0d want 20", bus.dmem_addr); else n_pass++;
    n_checks++; if (bus.ld_gnt !== 1'b0) $display("FAIL full_gnt_held got %0b want 0", bus.ld_gnt); else n_pass++;
    n_checks++; if (bus.overflow_err !== 1'b0) $display("FAIL full_ovf_early got %0b want 0", bus.overflow_err); else n_pass++;
    @(negedge clk);
    bus.mat_res_en = 1'b0; bus.ld_req = 1'b0;
    #1;
    n_checks++; if (bus.overflow_err !== 1'b1) $display("FAIL full_ovf got %0b want 1", bus.overflow_err); else n_pass++;
    n_checks++; if (bus.wb_count !== 3'd3) $display("FAIL full_count_after got %0d want 3", bus.wb_count); else n_pass++;
    n_checks++; if (bus.dmem_addr !== 8'd21) $display("FAIL full_drain21 got %0d want 21", bus.dmem_addr); else n_pass++;
    @(negedge clk); #1;
    n_checks++; if (bus.dmem_addr !== 8'd22) $display("FAIL full_drain22 got %0d want 22", bus.dmem_addr); else n_pass++;
    @(negedge clk); #1;
    n_checks++; if (bus.dmem_addr !== 8'd23) $display("FAIL full_drain23 got %0d want 23", bus.dmem_addr); else n_pass++;
    n_checks++; if (bus.dmem_din !== row4(23, 23, 23, 23)) $display("FAIL full_drain23_din got %h", bus.dmem_din); else n_pass++;
    @(negedge clk); #1;
    n_checks++; if (bus.wb_empty !== 1'b1) $display("FAIL full_dropped_empty got %0b want 1", bus.wb_empty); else n_pass++;
    n_checks++; if (bus.overflow_err !== 1'b1) $display("FAIL full_ovf_sticky got %0b want 1", bus.overflow_err); else n_pass++;
  endtask

  task automatic test_wrap_around();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.mat_res_en = 1'b1; bus.mat_res_addr = 8'(40 + i); bus.mat_res_din = row4(i, i + 100, i + 200, i + 300);
      #1;
      if (i > 0) begin
        n_checks++; if (bus.dmem_we !== 1'b1) $display("FAIL wrap_we[%0d] got %0b want 1", i, bus.dmem_we); else n_pass++;
        n_checks++; if (bus.dmem_addr !== 8'(39 + i)) $display("FAIL wrap_addr[%0d] got %0d want %0d", i, bus.dmem_addr, 39 + i); else n_pass++;
        n_checks++; if (bus.dmem_din !== row4(i - 1, i + 99, i + 199, i + 299)) $display("FAIL wrap_din[%0d] got %h", i, bus.dmem_din); else n_pass++;
        n_checks++; if (bus.wb_count !== 3'd1) $display("FAIL wrap_count[%0d] got %0d want 1", i, bus.wb_count); else n_pass++;
      end
    end
    @(negedge clk);
    bus.mat_res_en = 1'b0;
    #1;
    n_checks++; if (bus.dmem_addr !== 8'd49) $display("FAIL wrap_last_addr got %0d want 49", bus.dmem_addr); else n_pass++;
    n_checks++; if (bus.dmem_din !== row4(9, 109, 209, 309)) $display("FAIL wrap_last_din got %h", bus.dmem_din); else n_pass++;
    @(negedge clk); #1;
    n_checks++; if (bus.wb_empty !== 1'b1) $display("FAIL wrap_empty got %0b want 1", bus.wb_empty); else n_pass++;
  endtask

  task automatic test_reset_mid_drain();
    @(negedge clk);
    bus.ld_req = 1'b1; bus.ld_addr = 8'd250;
    bus.mat_res_en = 1'b1; bus.mat_res_addr = 8'd60; bus.mat_res_din = row4(60, 60, 60, 60);
    @(negedge clk);
    bus.mat_res_addr = 8'd61; bus.mat_res_din = row4(61, 61, 61, 61);
    @(negedge clk);
    bus.mat_res_addr = 8'd62; bus.mat_res_din = row4(62, 62, 62, 62);
    @(negedge clk);
    bus.mat_res_en = 1'b0; bus.ld_req = 1'b0;
    #1;
    n_checks++; if (bus.dmem_addr !== 8'd60) $display("FAIL rst_first_write got %0d want 60", bus.dmem_addr); else n_pass++;
    n_checks++; if (bus.wb_count !== 3'd3) $display("FAIL rst_count_pre got %0d want 3", bus.wb_count); else n_pass++;
    @(negedge clk);
    rstn = 1'b0; bus.ld_req = 1'b1;
    #1;
    n_checks++; if (bus.dmem_en !== 1'b0) $display("FAIL rst_hold_en got %0b want 0", bus.dmem_en); else n_pass++;
    n_checks++; if (bus.dmem_we !== 1'b0) $display("FAIL rst_hold_we got %0b want 0", bus.dmem_we); else n_pass++;
    n_checks++; if (bus.ld_gnt !== 1'b0) $display("FAIL rst_hold_gnt got %0b want 0", bus.ld_gnt); else n_pass++;
    @(negedge clk);
    rstn = 1'b1; bus.ld_req = 1'b0;
    #1;
    n_checks++; if (bus.wb_empty !== 1'b1) $display("FAIL rst_empty got %0b want 1", bus.wb_empty); else n_pass++;
    n_checks++; if (bus.wb_count !== 3'd0) $display("FAIL rst_count got %0d want 0", bus.wb_count); else n_pass++;
    n_checks++; if (bus.overflow_err !== 1'b0) $display("FAIL rst_ovf got %0b want 0", bus.overflow_err); else n_pass++;
    n_checks++; if (bus.ld_valid !== 1'b0) $display("FAIL rst_ld_valid got %0b want 0", bus.ld_valid); else n_pass++;
    n_checks++; if (bus.dmem_we !== 1'b0) $display("FAIL rst_no_write got %0b want 0", bus.dmem_we); else n_pass++;
    @(negedge clk); #1;
    n_checks++; if (bus.dmem_en !== 1'b0) $display("FAIL rst_no_write_later got %0b want 0", bus.dmem_en); else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rstn = 1'b0;
    bus.mat_res_en = 1'b0; bus.mat_res_addr = '0; bus.mat_res_din = '0;
    bus.ld_req = 1'b0; bus.ld_addr = '0;
    test_reset();
    test_single_store();
    test_load_priority();
    test_raw_hazard();
    test_full_overflow();
    test_wrap_around();
    test_reset_mid_drain();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
